hazard_stall_unit: RTL and testbench

- Control side of the 5-stage pipeline registers. Produces the IF/ID `load_enable`, the PC load enable, and the `hazard_reset` (bubble/flush) strobes for IF/ID and ID/EX.
- Also produces ID-stage operand forwarding selects.
- A small FSM sequences multi-cycle load-use stalls and single-cycle branch flushes.
- Saturating counters record stall and flush events for performance analysis.

---
 rtl/hazard_stall_unit.sv | 191 +++++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard control: load-use stall sequencing, branch flush strobes,
// ID-stage operand forwarding selects and saturating stall/flush counters.

// Per-operand forwarding select. Nearest producer wins; r0 is never forwarded.
module hazard_fwd_sel (
  input  logic [4:0] src,
  input  logic [4:0] ex_rw,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] mem_rw,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rw,
  input  logic       wb_reg_write,
  output logic [1:0] sel
);

  // EX > MEM > WB > register file; loads in EX have no ALU result to forward
  always_comb begin
    sel = 2'b00;
    if (ex_reg_write && !ex_mem_read && ex_rw != 5'd0 && ex_rw == src)
      sel = 2'b01;
    else if (mem_reg_write && mem_rw != 5'd0 && mem_rw == src)
      sel = 2'b10;
    else if (wb_reg_write && wb_rw != 5'd0 && wb_rw == src)
      sel = 2'b11;
  end

endmodule

// Saturating event counter with synchronous clear taking precedence.
module hazard_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Hold at all-ones rather than wrapping so long runs stay meaningful
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          count <= '0;
    else if (clear)                      count <= '0;
    else if (inc && count != {CNT_W{1'b1}}) count <= count + 1'b1;
  end

endmodule

module hazard_stall_unit #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rw,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rw,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rw,
  input  logic             wb_reg_write,
  input  logic             ex_branch_taken,
  input  logic             cnt_clear,
  output logic             pc_load_enable,
  output logic             if_id_load_enable,
  output logic             if_id_hazard_reset,
  output logic             id_ex_hazard_reset,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             busy_stall
);

  localparam int NUM_OPS = 2;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t     state;
  logic [1:0] remaining;

  logic haz_a, haz_b, lu;
  logic hold;
  logic stall_inc, flush_inc;

  logic [NUM_OPS-1:0][4:0] op_src;
  logic [NUM_OPS-1:0][1:0] op_sel;

  // Load-use: a load in EX targets a register the ID instruction reads
  assign haz_a = ex_mem_read && ex_rw != 5'd0 && ex_rw == id_rs;
  assign haz_b = ex_mem_read && ex_rw != 5'd0 && ex_rw == id_rt && id_uses_rt;
  assign lu    = haz_a | haz_b;

  // Bubble in STALL regardless of lu (EX already holds a bubble); branch overrides
  assign hold      = !ex_branch_taken && (state == STALL || lu);
  assign stall_inc = hold;
  assign flush_inc = ex_branch_taken;

  // Strobes to the pipeline registers
  always_comb begin
    pc_load_enable     = 1'b1;
    if_id_load_enable  = 1'b1;
    if_id_hazard_reset = 1'b0;
    id_ex_hazard_reset = 1'b0;
    if (ex_branch_taken) begin
      if_id_hazard_reset = 1'b1;
      id_ex_hazard_reset = 1'b1;
    end else if (hold) begin
      pc_load_enable     = 1'b0;
      if_id_load_enable  = 1'b0;
      id_ex_hazard_reset = 1'b1;
    end
  end

  assign busy_stall = (state == STALL);

  // Stall sequencer: the RUN cycle that detects lu is the first bubble,
  // STALL supplies the remaining LOAD_USE_STALLS-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      remaining <= 2'd0;
    end else if (ex_branch_taken) begin
      state     <= RUN;
      remaining <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (lu && LOAD_USE_STALLS > 1) begin
            state     <= STALL;
            remaining <= 2'(LOAD_USE_STALLS - 1);
          end
        end
        STALL: begin
          if (remaining <= 2'd1) begin
            state     <= RUN;
            remaining <= 2'd0;
          end else begin
            remaining <= remaining - 2'd1;
          end
        end
        default: begin
          state     <= RUN;
          remaining <= 2'd0;
        end
      endcase
    end
  end

  assign op_src[0] = id_rs;
  assign op_src[1] = id_rt;

  // One forwarding select per ID operand, evaluated in every state
  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    hazard_fwd_sel u_fwd (
      .src           (op_src[i]),
      .ex_rw         (ex_rw),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_read   (ex_mem_read),
      .mem_rw        (mem_rw),
      .mem_reg_write (mem_reg_write),
      .wb_rw         (wb_rw),
      .wb_reg_write  (wb_reg_write),
      .sel           (op_sel[i])
    );
  end

  assign fwd_a_sel = op_sel[0];
  assign fwd_b_sel = op_sel[1];

  hazard_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (stall_inc),
    .count (stall_count)
  );

  hazard_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: one instance with a single load-use bubble, one with three.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rw, mem_rw, wb_rw;
  logic id_uses_rt, ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
  logic ex_branch_taken, cnt_clear;

  logic pc1, ifle1, ifhr1, idhr1, busy1;
  logic [1:0] fa1, fb1;
  logic [15:0] sc1, fc1;
  logic pc3, ifle3, ifhr3, idhr3, busy3;
  logic [1:0] fa3, fb3;
  logic [15:0] sc3, fc3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.LOAD_USE_STALLS(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rw(ex_rw), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rw(mem_rw), .mem_reg_write(mem_reg_write), .wb_rw(wb_rw), .wb_reg_write(wb_reg_write),
    .ex_branch_taken(ex_branch_taken), .cnt_clear(cnt_clear),
    .pc_load_enable(pc1), .if_id_load_enable(ifle1), .if_id_hazard_reset(ifhr1),
    .id_ex_hazard_reset(idhr1), .fwd_a_sel(fa1), .fwd_b_sel(fb1),
    .stall_count(sc1), .flush_count(fc1), .busy_stall(busy1));

  hazard_stall_unit #(.LOAD_USE_STALLS(3), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rw(ex_rw), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rw(mem_rw), .mem_reg_write(mem_reg_write), .wb_rw(wb_rw), .wb_reg_write(wb_reg_write),
    .ex_branch_taken(ex_branch_taken), .cnt_clear(cnt_clear),
    .pc_load_enable(pc3), .if_id_load_enable(ifle3), .if_id_hazard_reset(ifhr3),
    .id_ex_hazard_reset(idhr3), .fwd_a_sel(fa3), .fwd_b_sel(fb3),
    .stall_count(sc3), .flush_count(fc3), .busy_stall(busy3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rw = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_rw = 0; mem_reg_write = 0; wb_rw = 0; wb_reg_write = 0;
    ex_branch_taken = 0; cnt_clear = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1'b0; #1; reset = 1'b1;
    step();
  endtask

  task automatic set_lu(input logic [4:0] r);
    ex_mem_read = 1; ex_reg_write = 1; ex_rw = r; id_rs = r;
  endtask

  initial begin
    clr_in();
    reset = 1'b0;
    #2;
    chk("rst_pc", pc1, 1);
    chk("rst_ifle", ifle1, 1);
    chk("rst_sc", sc1, 0);
    chk("rst_fc", fc1, 0);
    chk("rst_busy3", busy3, 0);
    #1 reset = 1'b1;
    step();

    // load-use on rs, single bubble
    set_lu(5);
    #1;
    chk("lu1_pc", pc1, 0);
    chk("lu1_ifle", ifle1, 0);
    chk("lu1_idhr", idhr1, 1);
    chk("lu1_ifhr", ifhr1, 0);
    chk("lu1_fa_load_in_ex", fa1, 2'b00);
    step();
    clr_in(); mem_rw = 5; mem_reg_write = 1; id_rs = 5;
    #1;
    chk("lu1_fa_mem", fa1, 2'b10);
    chk("lu1_pc_after", pc1, 1);
    chk("lu1_sc", sc1, 1);
    chk("lu1_busy", busy1, 0);

    // three-bubble load-use on rt
    do_reset();
    ex_mem_read = 1; ex_rw = 9; id_rt = 9; id_uses_rt = 1; id_rs = 3;
    #1;
    chk("lu3_c1_pc", pc3, 0);
    chk("lu3_c1_busy", busy3, 0);
    step();
    chk("lu3_c2_pc", pc3, 0);
    chk("lu3_c2_ifle", ifle3, 0);
    chk("lu3_c2_busy", busy3, 1);
    step();
    chk("lu3_c3_pc", pc3, 0);
    chk("lu3_c3_idhr", idhr3, 1);
    chk("lu3_c3_busy", busy3, 1);
    ex_mem_read = 0;
    step();
    chk("lu3_c4_pc", pc3, 1);
    chk("lu3_c4_busy", busy3, 0);
    chk("lu3_sc", sc3, 3);
    ex_mem_read = 1; id_uses_rt = 0;
    #1;
    chk("nort_pc", pc3, 1);
    chk("nort_idhr", idhr3, 0);
    step();
    chk("nort_sc", sc3, 3);

    // branch beats load-use
    do_reset();
    set_lu(5); ex_branch_taken = 1;
    #1;
    chk("br_ifhr", ifhr1, 1);
    chk("br_idhr", idhr1, 1);
    chk("br_pc", pc1, 1);
    chk("br_ifle", ifle1, 1);
    step();
    clr_in();
    #1;
    chk("br_fc", fc1, 1);
    chk("br_sc", sc1, 0);

    // branch during STALL
    do_reset();
    set_lu(6);
    step();
    clr_in(); ex_branch_taken = 1;
    #1;
    chk("brst_busy", busy3, 1);
    chk("brst_ifhr", ifhr3, 1);
    chk("brst_pc", pc3, 1);
    step();
    ex_branch_taken = 0;
    #1;
    chk("brst_busy_after", busy3, 0);
    chk("brst_fc", fc3, 1);
    chk("brst_sc", sc3, 1);
    chk("brst_pc_after", pc3, 1);

    // asynchronous reset mid-STALL
    do_reset();
    set_lu(6);
    step();
    chk("rstst_busy_pre", busy3, 1);
    ex_mem_read = 0; reset = 1'b0;
    #1;
    chk("rstst_busy", busy3, 0);
    chk("rstst_sc", sc3, 0);
    chk("rstst_fc", fc3, 0);
    chk("rstst_pc", pc3, 1);
    chk("rstst_idhr", idhr3, 0);
    chk("rstst_ifhr", ifhr3, 0);
    reset = 1'b1;
    step();

    // forwarding priority
    clr_in();
    ex_rw = 7; mem_rw = 7; wb_rw = 7;
    ex_reg_write = 1; mem_reg_write = 1; wb_reg_write = 1;
    id_rs = 7; id_rt = 7;
    #1;
    chk("fwd_ex_a", fa1, 2'b01);
    chk("fwd_ex_b", fb1, 2'b01);
    ex_reg_write = 0;
    #1;
    chk("fwd_mem_a", fa1, 2'b10);
    mem_reg_write = 0;
    #1;
    chk("fwd_wb_a", fa1, 2'b11);
    id_rt = 4;
    #1;
    chk("fwd_none_b", fb1, 2'b00);
    step();
    clr_in(); wb_reg_write = 1; mem_reg_write = 1; ex_reg_write = 1;
    #1;
    chk("fwd_r0_a", fa1, 2'b00);
    chk("fwd_r0_b", fb1, 2'b00);
    step();

    // saturation and clear precedence
    do_reset();
    set_lu(5);
    repeat (65535) @(posedge clk);
    #1;
    chk("sat_full", sc1, 16'hFFFF);
    step();
    chk("sat_hold", sc1, 16'hFFFF);
    cnt_clear = 1;
    step();
    chk("sat_clear", sc1, 0);
    cnt_clear = 0;
    step();
    chk("sat_restart", sc1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
